// File: rtl/stream_pkg.sv
// Shared types and constants for the FIFO-to-stream reader and its skid buffer.
package stream_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    localparam int FRAME_COUNT_W = 16;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready buffer (output register plus skid register) carrying data and a last flag.
// in_ready depends only on local state, so there is no combinational path from out_ready upstream.
module skid_buffer
    import stream_pkg::*;
#(
    parameter int P_DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [P_DATA_WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [P_DATA_WIDTH-1:0] out_data,
    output logic                    out_last
);

    buf_state_t              state;
    buf_state_t              state_next;
    logic [P_DATA_WIDTH-1:0] skid_data;
    logic                    skid_last;
    logic                    push;
    logic                    hs;
    logic                    load_out;
    logic                    load_skid;
    logic                    move_skid;

    assign in_ready  = (state != ST_TWO) && !rst;
    assign out_valid = (state != ST_EMPTY);
    assign push      = in_valid && in_ready;
    assign hs        = out_valid && out_ready;

    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (push) begin
                    load_out   = 1'b1;
                    state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && hs) begin
                    load_out = 1'b1;
                end else if (push) begin
                    load_skid  = 1'b1;
                    state_next = ST_TWO;
                end else if (hs) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (hs) begin
                    move_skid  = 1'b1;
                    state_next = ST_ONE;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            out_last  <= 1'b0;
            skid_last <= 1'b0;
        end else begin
            state <= state_next;
            if (load_out) begin
                out_last <= in_last;
            end else if (move_skid) begin
                out_last <= skid_last;
            end else if (hs) begin
                out_last <= 1'b0;
            end
            if (load_skid) begin
                skid_last <= in_last;
            end
        end
    end

    // Payload registers carry no reset; validity is tracked by state alone.
    always_ff @(posedge clk) begin
        if (load_out) begin
            out_data <= in_data;
        end else if (move_skid) begin
            out_data <= skid_data;
        end
        if (load_skid) begin
            skid_data <= in_data;
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a first-word-fall-through FIFO into a framed valid/ready stream.
// Framing (beat count, last tag) is decided at pop time; the skid buffer only carries it.
module fifo_stream_reader
    import stream_pkg::*;
#(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_LEN_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [P_DATA_WIDTH-1:0]  fifo_data,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    input  logic [P_LEN_WIDTH-1:0]   frame_len,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [P_DATA_WIDTH-1:0]  m_data,
    output logic                     m_last,
    output logic [FRAME_COUNT_W-1:0] frame_count
);

    localparam logic [P_LEN_WIDTH-1:0]   LEN_ONE = P_LEN_WIDTH'(1);
    localparam logic [FRAME_COUNT_W-1:0] FC_ONE  = FRAME_COUNT_W'(1);

    logic                   buf_ready;
    logic [P_LEN_WIDTH-1:0] beat_cnt;
    logic [P_LEN_WIDTH-1:0] len_q;
    logic [P_LEN_WIDTH-1:0] len_eff;
    logic                   beat_last;

    assign fifo_rd_en = !fifo_empty && buf_ready;

    // The first beat of a frame uses the live frame_len (zero means one); later beats use the latched copy.
    assign len_eff   = (beat_cnt == '0) ? ((frame_len == '0) ? LEN_ONE : frame_len) : len_q;
    assign beat_last = (beat_cnt == (len_eff - LEN_ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt    <= '0;
            len_q       <= LEN_ONE;
            frame_count <= '0;
        end else begin
            if (fifo_rd_en) begin
                if (beat_cnt == '0) begin
                    len_q <= len_eff;
                end
                beat_cnt <= beat_last ? '0 : (beat_cnt + LEN_ONE);
            end
            if (m_valid && m_ready && m_last) begin
                frame_count <= frame_count + FC_ONE;
            end
        end
    end

    skid_buffer #(
        .P_DATA_WIDTH(P_DATA_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .in_valid (!fifo_empty),
        .in_ready (buf_ready),
        .in_data  (fifo_data),
        .in_last  (beat_last),
        .out_valid(m_valid),
        .out_ready(m_ready),
        .out_data (m_data),
        .out_last (m_last)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: FWFT FIFO model on the input side, handshake monitor on the stream side.
module tb_fifo_stream_reader;

    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [LW-1:0] frame_len = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [15:0]   frame_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] mem [0:1023];
    int            wr_ptr   = 0;
    int            rd_ptr   = 0;
    logic          inf_mode = 1'b0;

    assign fifo_empty = inf_mode ? 1'b0 : (rd_ptr == wr_ptr);
    assign fifo_data  = inf_mode ? DW'(rd_ptr) : mem[rd_ptr[9:0]];

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .P_DATA_WIDTH(DW),
        .P_LEN_WIDTH (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .frame_len  (frame_len),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .frame_count(frame_count)
    );

    logic [DW-1:0] obs_data [0:1023];
    logic          obs_last [0:1023];
    int            obs_cyc  [0:1023];
    int            out_n      = 0;
    int            cyc        = 0;
    int            occ        = 0;
    int            stable_err = 0;
    int            two_rd_err = 0;
    int            rst_rd_err = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    // Stream-side monitor plus the FIFO pop pointer.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
        if (rst) begin
            if (fifo_rd_en) rst_rd_err <= rst_rd_err + 1;
            occ        <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                obs_data[out_n[9:0]] <= m_data;
                obs_last[out_n[9:0]] <= m_last;
                obs_cyc[out_n[9:0]]  <= cyc;
                out_n <= out_n + 1;
            end
            if (occ == 2 && fifo_rd_en) two_rd_err <= two_rd_err + 1;
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
                stable_err <= stable_err + 1;
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
            prev_last  <= m_last;
            occ <= occ + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
        end
    end

    task automatic push_word(input logic [DW-1:0] w);
        mem[wr_ptr[9:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_beats(input int target, input int budget, output bit ok);
        int c = 0;
        while (out_n < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (out_n >= target);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b expected 0", m_valid); else n_pass++;
        n_checks++; if (m_last !== 1'b0) $display("FAIL reset_m_last: got %b expected 0", m_last); else n_pass++;
        n_checks++; if (frame_count !== 16'h0) $display("FAIL reset_frame_count: got %0h expected 0", frame_count); else n_pass++;
        n_checks++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (m_valid !== 1'b0) $display("FAIL idle_m_valid: got %b expected 0", m_valid); else n_pass++;
    endtask

    task automatic test_basic();
        int base;
        bit ok;
        frame_len = 8'd4;
        m_ready   = 1'b1;
        base      = out_n;
        for (int i = 0; i < 8; i++) push_word(DW'(i));
        wait_beats(base + 8, 50, ok);
        n_checks++; if (!ok) $display("FAIL basic_timeout: got %0d beats expected 8", out_n - base); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (obs_data[(base + i) % 1024] !== DW'(i))
                $display("FAIL basic_data[%0d]: got %0h expected %0h", i, obs_data[(base + i) % 1024], i);
            else n_pass++;
            n_checks++;
            if (obs_last[(base + i) % 1024] !== (i == 3 || i == 7))
                $display("FAIL basic_last[%0d]: got %b expected %b", i, obs_last[(base + i) % 1024], (i == 3 || i == 7));
            else n_pass++;
        end
        n_checks++;
        if (obs_cyc[(base + 7) % 1024] - obs_cyc[base % 1024] !== 7)
            $display("FAIL basic_throughput: got %0d cycles expected 7", obs_cyc[(base + 7) % 1024] - obs_cyc[base % 1024]);
        else n_pass++;
        n_checks++; if (frame_count !== 16'd2) $display("FAIL basic_frame_count: got %0d expected 2", frame_count); else n_pass++;
    endtask

    task automatic test_stall();
        int base;
        int c;
        frame_len = 8'd3;
        m_ready   = 1'b1;
        base      = out_n;
        for (int i = 0; i < 6; i++) push_word(DW'(16 + i));
        c = 0;
        while (out_n < base + 6 && c < 60) begin
            @(negedge clk);
            m_ready = ~m_ready;
            c++;
        end
        m_ready = 1'b1;
        n_checks++; if (out_n < base + 6) $display("FAIL stall_timeout: got %0d beats expected 6", out_n - base); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (obs_data[(base + i) % 1024] !== DW'(16 + i))
                $display("FAIL stall_data[%0d]: got %0h expected %0h", i, obs_data[(base + i) % 1024], 16 + i);
            else n_pass++;
            n_checks++;
            if (obs_last[(base + i) % 1024] !== (i == 2 || i == 5))
                $display("FAIL stall_last[%0d]: got %b expected %b", i, obs_last[(base + i) % 1024], (i == 2 || i == 5));
            else n_pass++;
        end
        n_checks++; if (stable_err !== 0) $display("FAIL stall_stable: got %0d changes expected 0", stable_err); else n_pass++;
        n_checks++; if (two_rd_err !== 0) $display("FAIL stall_rd_in_two: got %0d pops expected 0", two_rd_err); else n_pass++;
        n_checks++; if (frame_count !== 16'd4) $display("FAIL stall_frame_count: got %0d expected 4", frame_count); else n_pass++;
    endtask

    task automatic test_len_zero();
        int base;
        bit ok;
        frame_len = 8'd0;
        m_ready   = 1'b1;
        base      = out_n;
        for (int i = 0; i < 3; i++) push_word(DW'(32 + i));
        wait_beats(base + 3, 30, ok);
        n_checks++; if (!ok) $display("FAIL zero_timeout: got %0d beats expected 3", out_n - base); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs_data[(base + i) % 1024] !== DW'(32 + i))
                $display("FAIL zero_data[%0d]: got %0h expected %0h", i, obs_data[(base + i) % 1024], 32 + i);
            else n_pass++;
            n_checks++;
            if (obs_last[(base + i) % 1024] !== 1'b1)
                $display("FAIL zero_last[%0d]: got %b expected 1", i, obs_last[(base + i) % 1024]);
            else n_pass++;
        end
        n_checks++; if (frame_count !== 16'd7) $display("FAIL zero_frame_count: got %0d expected 7", frame_count); else n_pass++;
    endtask

    task automatic test_len_change();
        int base;
        bit ok;
        frame_len = 8'd4;
        m_ready   = 1'b1;
        base      = out_n;
        for (int i = 0; i < 8; i++) begin
            push_word(DW'(40 + i));
            if (i == 2) frame_len = 8'd2;
            @(negedge clk);
        end
        wait_beats(base + 8, 30, ok);
        n_checks++; if (!ok) $display("FAIL change_timeout: got %0d beats expected 8", out_n - base); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (obs_data[(base + i) % 1024] !== DW'(40 + i))
                $display("FAIL change_data[%0d]: got %0h expected %0h", i, obs_data[(base + i) % 1024], 40 + i);
            else n_pass++;
            n_checks++;
            if (obs_last[(base + i) % 1024] !== (i == 3 || i == 5 || i == 7))
                $display("FAIL change_last[%0d]: got %b expected %b", i, obs_last[(base + i) % 1024], (i == 3 || i == 5 || i == 7));
            else n_pass++;
        end
        n_checks++; if (frame_count !== 16'd10) $display("FAIL change_frame_count: got %0d expected 10", frame_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        logic [DW-1:0] exp_d [0:3];
        logic          exp_l [0:3];
        exp_d[0] = 62; exp_d[1] = 63; exp_d[2] = 64; exp_d[3] = 65;
        exp_l[0] = 0;  exp_l[1] = 1;  exp_l[2] = 0;  exp_l[3] = 1;
        frame_len = 8'd4;
        m_ready   = 1'b0;
        push_word(DW'(60));
        push_word(DW'(61));
        push_word(DW'(62));
        repeat (3) @(negedge clk);
        n_checks++; if (m_valid !== 1'b1) $display("FAIL two_m_valid: got %b expected 1", m_valid); else n_pass++;
        n_checks++; if (fifo_rd_en !== 1'b0) $display("FAIL two_rd_en: got %b expected 0", fifo_rd_en); else n_pass++;
        rst = 1'b1;
        n_checks++; if (fifo_rd_en !== 1'b0) $display("FAIL rst_rd_en_same_cycle: got %b expected 0", fifo_rd_en); else n_pass++;
        @(negedge clk);
        n_checks++; if (m_valid !== 1'b0) $display("FAIL midrst_m_valid: got %b expected 0", m_valid); else n_pass++;
        n_checks++; if (fifo_rd_en !== 1'b0) $display("FAIL midrst_rd_en: got %b expected 0", fifo_rd_en); else n_pass++;
        n_checks++; if (frame_count !== 16'd0) $display("FAIL midrst_frame_count: got %0d expected 0", frame_count); else n_pass++;
        @(negedge clk);
        rst       = 1'b0;
        frame_len = 8'd2;
        m_ready   = 1'b1;
        base      = out_n;
        push_word(DW'(63));
        push_word(DW'(64));
        push_word(DW'(65));
        wait_beats(base + 4, 30, ok);
        n_checks++; if (!ok) $display("FAIL midrst_timeout: got %0d beats expected 4", out_n - base); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_data[(base + i) % 1024] !== exp_d[i])
                $display("FAIL midrst_data[%0d]: got %0h expected %0h", i, obs_data[(base + i) % 1024], exp_d[i]);
            else n_pass++;
            n_checks++;
            if (obs_last[(base + i) % 1024] !== exp_l[i])
                $display("FAIL midrst_last[%0d]: got %b expected %b", i, obs_last[(base + i) % 1024], exp_l[i]);
            else n_pass++;
        end
        n_checks++; if (frame_count !== 16'd2) $display("FAIL midrst_frames_after: got %0d expected 2", frame_count); else n_pass++;
        n_checks++; if (rst_rd_err !== 0) $display("FAIL rst_pops: got %0d expected 0", rst_rd_err); else n_pass++;
    endtask

    task automatic test_wrap();
        int base;
        bit ok;
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        frame_len = 8'd1;
        m_ready   = 1'b1;
        base      = out_n;
        inf_mode  = 1'b1;
        wait_beats(base + 65535, 70000, ok);
        m_ready  = 1'b0;
        inf_mode = 1'b0;
        wr_ptr   = rd_ptr;
        n_checks++; if (!ok) $display("FAIL wrap_timeout: got %0d beats expected 65535", out_n - base); else n_pass++;
        n_checks++; if (frame_count !== 16'hFFFF) $display("FAIL wrap_preset: got %0h expected ffff", frame_count); else n_pass++;
        @(negedge clk);
        n_checks++; if (frame_count !== 16'hFFFF) $display("FAIL wrap_hold: got %0h expected ffff", frame_count); else n_pass++;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        n_checks++; if (frame_count !== 16'h0000) $display("FAIL wrap_rollover: got %0h expected 0", frame_count); else n_pass++;
        m_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_len_zero();
        test_len_change();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 32: width of data words.
REQ-002 SHALL have parameter P_LEN_WIDTH, default 8: width of frame_len and beat counter.
REQ-003 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port fifo_data  input  P_DATA_WIDTH: FWFT FIFO head word, valid when fifo_empty low.
REQ-006 SHALL have port fifo_empty  input  1: FIFO has no word at head.
REQ-007 SHALL have port fifo_rd_en  output  1: pops FIFO head this cycle.
REQ-008 SHALL have port frame_len  input  P_LEN_WIDTH: beats per frame, sampled at frame start.
REQ-009 SHALL have port m_valid  output  1: stream beat valid.
REQ-010 SHALL have port m_ready  input  1: downstream accepts beat.
REQ-011 SHALL have port m_data  output  P_DATA_WIDTH: stream beat data.
REQ-012 SHALL have port m_last  output  1: final beat of frame.
REQ-013 SHALL have port frame_count  output  16: completed frames, wraps modulo 2^16.

Function
REQ-014 SHALL drive fifo_rd_en = !fifo_empty && !skid_valid, combinationally free of m_ready (no comb path m_ready -> fifo_rd_en).
REQ-015 SHALL hold a two-entry buffer: output register (m_data/m_last/m_valid) and skid register (data, last, skid_valid).
REQ-016 SHALL implement states EMPTY (m_valid=0), ONE (m_valid=1, skid empty), TWO (both full).
REQ-017 EMPTY: pop -> word to output register, go ONE; no pop -> stay.
REQ-018 ONE: pop and handshake -> output register reloaded, stay ONE; pop, no handshake -> word to skid, go TWO; handshake, no pop -> EMPTY; neither -> stay.
REQ-019 TWO: handshake -> skid moves to output register, go ONE; no pop possible (fifo_rd_en=0); no handshake -> stay.
REQ-020 Handshake SHALL be m_valid && m_ready; m_data/m_last SHALL be stable while m_valid && !m_ready.
REQ-021 Latency: word popped in cycle N SHALL appear on m_data no earlier than cycle N+1; with m_ready held high and FIFO never empty, throughput SHALL be one beat per cycle.
REQ-022 Beat counter (P_LEN_WIDTH bits) SHALL advance on every pop, not on handshake; m_last attached at pop time.
REQ-023 On the first pop of a frame (counter 0), frame_len SHALL be latched; frame_len=0 SHALL be treated as 1.
REQ-024 The pop whose count equals latched length minus 1 SHALL be tagged last and SHALL reset counter to 0; frame_len changes mid-frame SHALL have no effect.
REQ-025 A single-beat frame (length 1) SHALL be tagged last on its first pop.
REQ-026 frame_count SHALL increment by 1 on each handshake with m_last=1, wrapping 0xFFFF -> 0x0000.
REQ-027 Beats SHALL be emitted in FIFO order; no beat SHALL be dropped or duplicated.

Reset
REQ-028 rst SHALL return to EMPTY: m_valid=0, skid_valid=0, m_last=0, beat counter=0, frame_count=0; m_data reset value unspecified.
REQ-029 fifo_rd_en SHALL be 0 during any cycle rst is high; rst mid-frame SHALL discard buffered beats and partial frame state.

Structure
REQ-030 SHALL place the state enum (EMPTY/ONE/TWO) and the frame_count width constant (16) in shared package stream_pkg.
REQ-031 The two-entry buffer SHALL be a sub-module skid_buffer (data+last payload, valid/ready both sides), reusable elsewhere; framing logic stays in fifo_stream_reader.

Verification
REQ-032 frame_len=4, FIFO preloaded 0..7, m_ready=1 -> 8 consecutive beats 0..7, m_last on 3 and 7, frame_count=2.
REQ-033 frame_len=3, m_ready toggling 1,0,1,0 -> data 0..5 unchanged/in order while stalled, m_last on 2 and 5, fifo_rd_en never high in TWO.
REQ-034 frame_len=0, 3 words -> 3 beats each m_last=1, frame_count=3.
REQ-035 frame_len=4 at start, changed to 2 after beat 1 -> m_last on beat 3, next frame uses length 2.
REQ-036 frame_count preset by 65535 frames of length 1, one more -> frame_count=0x0000.
REQ-037 rst asserted in TWO mid-frame -> next cycle m_valid=0, fifo_rd_en=0 while rst high, next frame counts from beat 0.
